// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the UART receive/transmit buffering blocks.
//   C_DATAWIDTH / C_DEPTH / C_CNTWIDTH : default byte width, FIFO depth and
//                                        statistics counter width
//   ptr_width()                        : pointer width for a given FIFO depth
//   sat_inc()                          : saturating +1 for counters up to 32 bits
//   fifo_evt_t                         : per-cycle FIFO event summary
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned C_DATAWIDTH = 8;
  localparam int unsigned C_DEPTH     = 16;
  localparam int unsigned C_CNTWIDTH  = 16;

  // Depth is a power of two >= 2, so $clog2 gives an exact wrap-around pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned C_PTRWIDTH = ptr_width(C_DEPTH);

  // Counter value is carried in 32 bits; callers truncate back to their width.
  // The counter holds at all-ones for its own width instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

  typedef struct packed {
    logic push;     // byte offered by the receiver
    logic pop;      // consumer handshake completed
    logic drop;     // byte offered while full and not popping
  } fifo_evt_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Generic single-clock circular FIFO with first-word fall-through read.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wr_data : write request and data; accepted when not full or when a
//                   pop happens in the same cycle
//   pop           : read request; ignored while empty
//   rd_data       : entry at the read pointer (combinational from rd_ptr)
//   level         : number of stored entries (registered)
//   full, empty   : decoded from level
//   push_refused  : push requested but not accepted this cycle
// ---------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH = C_DATAWIDTH,
  parameter int unsigned G_DEPTH     = C_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [G_DATAWIDTH-1:0]     wr_data,
  input  logic                       pop,
  output logic [G_DATAWIDTH-1:0]     rd_data,
  output logic [$clog2(G_DEPTH):0]   level,
  output logic                       full,
  output logic                       empty,
  output logic                       push_refused
);

  localparam int unsigned C_PW = ptr_width(G_DEPTH);
  localparam int unsigned C_LW = $clog2(G_DEPTH) + 1;

  logic [G_DATAWIDTH-1:0] mem [G_DEPTH];
  logic [C_PW-1:0]        wr_ptr;
  logic [C_PW-1:0]        rd_ptr;
  logic [C_LW-1:0]        level_q;
  logic                   wr_en;
  logic                   rd_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == C_LW'(G_DEPTH));

  // A pop frees the slot the push needs, so full+pop still accepts the push.
  assign rd_en        = pop && !empty;
  assign wr_en        = push && (!full || rd_en);
  assign push_refused = push && !wr_en;

  // Storage is deliberately not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + C_PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + C_PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + C_LW'(1);
        2'b01:   level_q <= level_q - C_LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // When empty this still shows the last entry read; consumers ignore it.
  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer behind the UART receiver: buffers received bytes in a
// FIFO presented as a valid/ready stream, and keeps receiver error statistics.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   uart_rxdata, uart_rxvalid   : byte strobe from the receiver
//   overrun_error, frame_error  : one-cycle error pulses from the receiver
//   m_tdata, m_tvalid, m_tready : output stream (pop on m_tvalid && m_tready)
//   level, full, empty          : FIFO occupancy
//   drop_error                  : sticky, a byte was lost to a full FIFO
//   clr_stats                   : clears drop_error and both error counters
//   frame_err_cnt               : saturating count of frame_error pulses
//   overrun_err_cnt             : saturating count of overrun_error pulses
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH = C_DATAWIDTH,
  parameter int unsigned G_DEPTH     = C_DEPTH,
  parameter int unsigned G_CNTWIDTH  = C_CNTWIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [G_DATAWIDTH-1:0]     uart_rxdata,
  input  logic                       uart_rxvalid,
  input  logic                       overrun_error,
  input  logic                       frame_error,
  output logic [G_DATAWIDTH-1:0]     m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(G_DEPTH):0]   level,
  output logic                       full,
  output logic                       empty,
  output logic                       drop_error,
  input  logic                       clr_stats,
  output logic [G_CNTWIDTH-1:0]      frame_err_cnt,
  output logic [G_CNTWIDTH-1:0]      overrun_err_cnt
);

  fifo_evt_t evt;
  logic      fifo_empty;
  logic      fifo_full;
  logic      push_refused;

  // m_tvalid comes from registered level, so a stray m_tready never pops.
  assign evt.push = uart_rxvalid;
  assign evt.pop  = m_tvalid && m_tready;
  assign evt.drop = push_refused;

  uart_sync_fifo #(
    .G_DATAWIDTH (G_DATAWIDTH),
    .G_DEPTH     (G_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (evt.push),
    .wr_data      (uart_rxdata),
    .pop          (evt.pop),
    .rd_data      (m_tdata),
    .level        (level),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .push_refused (push_refused)
  );

  assign m_tvalid = !fifo_empty;
  assign empty    = fifo_empty;
  assign full     = fifo_full;

  // Clear first, then apply this cycle's event, so a coinciding event
  // survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_error <= 1'b0;
    end else if (clr_stats) begin
      drop_error <= evt.drop;
    end else if (evt.drop) begin
      drop_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_cnt <= '0;
    end else if (clr_stats) begin
      frame_err_cnt <= frame_error ? G_CNTWIDTH'(1) : '0;
    end else if (frame_error) begin
      frame_err_cnt <= G_CNTWIDTH'(sat_inc(32'(frame_err_cnt), G_CNTWIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_err_cnt <= '0;
    end else if (clr_stats) begin
      overrun_err_cnt <= overrun_error ? G_CNTWIDTH'(1) : '0;
    end else if (overrun_error) begin
      overrun_err_cnt <= G_CNTWIDTH'(sat_inc(32'(overrun_err_cnt), G_CNTWIDTH));
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] uart_rxdata = 8'h00;
  logic       uart_rxvalid = 1'b0;
  logic       overrun_error = 1'b0;
  logic       frame_error = 1'b0;
  logic       m_tready = 1'b0;
  logic       clr_stats = 1'b0;

  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        drop_error;
  logic [15:0] frame_err_cnt;
  logic [15:0] overrun_err_cnt;

  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic [4:0]  s_level;
  logic        s_full;
  logic        s_empty;
  logic        s_drop_error;
  logic [3:0]  s_frame_err_cnt;
  logic [3:0]  s_overrun_err_cnt;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rxdata     (uart_rxdata),
    .uart_rxvalid    (uart_rxvalid),
    .overrun_error   (overrun_error),
    .frame_error     (frame_error),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .level           (level),
    .full            (full),
    .empty           (empty),
    .drop_error      (drop_error),
    .clr_stats       (clr_stats),
    .frame_err_cnt   (frame_err_cnt),
    .overrun_err_cnt (overrun_err_cnt)
  );

  // Narrow-counter copy sharing every input, used for saturation.
  uart_rx_fifo #(.G_CNTWIDTH(4)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .uart_rxdata     (uart_rxdata),
    .uart_rxvalid    (uart_rxvalid),
    .overrun_error   (overrun_error),
    .frame_error     (frame_error),
    .m_tdata         (s_tdata),
    .m_tvalid        (s_tvalid),
    .m_tready        (m_tready),
    .level           (s_level),
    .full            (s_full),
    .empty           (s_empty),
    .drop_error      (s_drop_error),
    .clr_stats       (clr_stats),
    .frame_err_cnt   (s_frame_err_cnt),
    .overrun_err_cnt (s_overrun_err_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue, raw event counts since last clear, sticky flag.
  logic [7:0] q[$];
  int         f_cnt = 0;
  int         o_cnt = 0;
  bit         m_drop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_model();
    chk("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("drop", 32'(drop_error), 32'(m_drop));
    chk("fcnt", 32'(frame_err_cnt), 32'(sat(f_cnt, 65535)));
    chk("ocnt", 32'(overrun_err_cnt), 32'(sat(o_cnt, 65535)));
    chk("sat_fcnt", 32'(s_frame_err_cnt), 32'(sat(f_cnt, 15)));
    chk("sat_ocnt", 32'(s_overrun_err_cnt), 32'(sat(o_cnt, 15)));
    chk("sat_level", 32'(s_level), 32'(q.size()));
    if (q.size() != 0) chk("tdata", 32'(m_tdata), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 after it.
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit rdy,
                      input bit fe, input bit oe, input bit clr);
    bit pop;
    bit was_full;
    rst = r; uart_rxvalid = v; uart_rxdata = d; m_tready = rdy;
    frame_error = fe; overrun_error = oe; clr_stats = clr;
    pop = (q.size() != 0) && rdy;
    was_full = (q.size() == DEPTH);
    @(posedge clk);
    if (r) begin
      q.delete(); f_cnt = 0; o_cnt = 0; m_drop = 1'b0;
    end else begin
      if (clr) begin f_cnt = 0; o_cnt = 0; m_drop = 1'b0; end
      if (pop) void'(q.pop_front());
      if (v) begin
        if (!was_full || pop) q.push_back(d);
        else m_drop = 1'b1;
      end
      if (fe) f_cnt++;
      if (oe) o_cnt++;
    end
    #1;
    check_model();
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 8'h00, rdy, 0, 0, 0);
  endtask

  task automatic push(input logic [7:0] d, input bit rdy);
    step(0, 1, d, rdy, 0, 0, 0);
  endtask

  typedef struct {
    bit         r, v, rdy, fe, oe, clr;
    logic [7:0] d;
    int         e_level;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_drop;
    int         e_f, e_o;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit r, input bit v, input logic [7:0] d,
                                  input bit rdy, input bit fe, input bit oe, input bit clr,
                                  input int e_level, input bit e_valid, input logic [7:0] e_data,
                                  input bit e_drop, input int e_f, input int e_o);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.fe = fe; t.oe = oe; t.clr = clr;
    t.e_level = e_level; t.e_valid = e_valid; t.e_data = e_data;
    t.e_drop = e_drop; t.e_f = e_f; t.e_o = e_o;
    vecs.push_back(t);
  endfunction

  initial begin
    //       r v d      rdy fe oe clr | lvl val data  drop f o
    add_vec(1, 0, 8'h00, 0, 0, 0, 0,    0, 0, 8'h00, 0, 0, 0);
    add_vec(0, 1, 8'h41, 0, 0, 0, 0,    1, 1, 8'h41, 0, 0, 0);
    add_vec(0, 1, 8'h42, 0, 0, 0, 0,    2, 1, 8'h41, 0, 0, 0);
    add_vec(0, 1, 8'h43, 0, 0, 0, 0,    3, 1, 8'h41, 0, 0, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 0,    2, 1, 8'h42, 0, 0, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 0,    1, 1, 8'h43, 0, 0, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 0,    0, 0, 8'h00, 0, 0, 0);
    add_vec(0, 1, 8'h5A, 1, 0, 0, 0,    1, 1, 8'h5A, 0, 0, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 0,    0, 0, 8'h00, 0, 0, 0);
    add_vec(0, 0, 8'h00, 1, 1, 0, 0,    0, 0, 8'h00, 0, 1, 0);
    add_vec(0, 0, 8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 2, 0);
    add_vec(0, 0, 8'h00, 0, 1, 1, 0,    0, 0, 8'h00, 0, 3, 1);
    add_vec(0, 0, 8'h00, 0, 0, 1, 0,    0, 0, 8'h00, 0, 3, 2);
    add_vec(0, 0, 8'h00, 0, 1, 0, 1,    0, 0, 8'h00, 0, 1, 0);
    add_vec(0, 0, 8'h00, 0, 0, 0, 1,    0, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].fe, vecs[i].oe, vecs[i].clr);
      chk("vec_level", 32'(level), 32'(vecs[i].e_level));
      chk("vec_tvalid", 32'(m_tvalid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk("vec_tdata", 32'(m_tdata), 32'(vecs[i].e_data));
      chk("vec_drop", 32'(drop_error), 32'(vecs[i].e_drop));
      chk("vec_fcnt", 32'(frame_err_cnt), 32'(vecs[i].e_f));
      chk("vec_ocnt", 32'(overrun_err_cnt), 32'(vecs[i].e_o));
    end

    // Overflow: 16 bytes fill it, the 17th is dropped.
    step(1, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) push(8'(i), 0);
    chk("ovf_full_before", 32'(full), 32'd1);
    chk("ovf_drop_before", 32'(drop_error), 32'd0);
    push(8'hFF, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_drop", 32'(drop_error), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_data", 32'(m_tdata), 32'(i));
      idle(1);
    end
    chk("ovf_empty", 32'(empty), 32'd1);
    chk("ovf_drop_sticky", 32'(drop_error), 32'd1);

    // Full with simultaneous pop: push accepted, 0xAA ends up last.
    step(0, 0, 8'h00, 0, 0, 0, 1);
    chk("clr_drop", 32'(drop_error), 32'd0);
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 0);
    push(8'hAA, 1);
    chk("fp_drop", 32'(drop_error), 32'd0);
    chk("fp_level", 32'(level), 32'd16);
    chk("fp_full", 32'(full), 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk("fp_data", 32'(m_tdata), 32'h10 + 32'(i));
      idle(1);
    end
    chk("fp_last", 32'(m_tdata), 32'hAA);
    idle(1);
    chk("fp_empty", 32'(empty), 32'd1);

    // Counter saturation on the 4-bit copy.
    step(0, 0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 0, 1, (i < 3), 0);
    chk("sat_frame15", 32'(s_frame_err_cnt), 32'd15);
    chk("wide_frame20", 32'(frame_err_cnt), 32'd20);
    chk("sat_overrun3", 32'(s_overrun_err_cnt), 32'd3);

    // Reset mid-stream discards stored bytes and statistics.
    for (int i = 0; i < 5; i++) step(0, 1, 8'h60 + 8'(i), 0, i[0], 0, 0);
    chk("mid_level5", 32'(level), 32'd5);
    step(1, 1, 8'h99, 1, 1, 1, 0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_fcnt", 32'(frame_err_cnt), 32'd0);
    chk("mid_ocnt", 32'(overrun_err_cnt), 32'd0);
    push(8'h33, 0);
    chk("mid_first", 32'(m_tdata), 32'h33);
    chk("mid_level1", 32'(level), 32'd1);

    // Randomized traffic with phases of slow/medium/fast consumers.
    for (int c = 0; c < 4000; c++) begin
      int rdy_pct;
      case ((c / 400) % 3)
        0:       rdy_pct = 15;
        1:       rdy_pct = 50;
        default: rdy_pct = 90;
      endcase
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 99) < 60,
           8'($urandom),
           $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each byte strobed out on the receiver's data/valid pair into a synchronous circular FIFO and presents it to the consumer on a valid/ready stream. It also accumulates saturating counts of the receiver's framing and overrun error pulses, and raises a sticky flag when a byte is lost because the FIFO is full.

## Interface
Parameters:
- G_DATAWIDTH, 8, byte width; matches the receiver's data width.
- G_DEPTH, 16, FIFO entries; power of two, ≥ 2.
- G_CNTWIDTH, 16, width of each error counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- uart_rxdata  in  G_DATAWIDTH  received byte from the receiver.
- uart_rxvalid  in  1  one-cycle strobe; uart_rxdata is valid while it is high.
- overrun_error  in  1  one-cycle pulse from the receiver.
- frame_error  in  1  one-cycle pulse from the receiver.
- m_tdata  out  G_DATAWIDTH  head-of-FIFO byte.
- m_tvalid  out  1  FIFO is not empty.
- m_tready  in  1  consumer accepts the byte; a pop occurs when m_tvalid && m_tready.
- level  out  $clog2(G_DEPTH)+1  number of entries currently stored.
- full  out  1  level == G_DEPTH.
- empty  out  1  level == 0.
- drop_error  out  1  sticky; a byte was discarded because the FIFO was full.
- clr_stats  in  1  clears drop_error and both counters.
- frame_err_cnt  out  G_CNTWIDTH  saturating count of frame_error pulses.
- overrun_err_cnt  out  G_CNTWIDTH  saturating count of overrun_error pulses.

## Operation
- Storage: register array of G_DEPTH entries.
- Pointers: wr_ptr and rd_ptr, each $clog2(G_DEPTH) bits. They wrap naturally modulo G_DEPTH.
- level: a separate counter; full and empty are decoded from it.
- Push condition: uart_rxvalid && (!full || pop). The push stores uart_rxdata at wr_ptr and increments wr_ptr.
- Dropped push: uart_rxvalid && full && !pop. The byte is discarded, drop_error is set to 1, and pointers and level are unchanged.
- Pop: increments rd_ptr.
- level update: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop or when idle.
- m_tdata: combinational read of mem[rd_ptr] (first-word fall-through).
- m_tdata when empty: holds the last-read entry and is don't-care to the consumer.
- Error counters: increment by 1 on each input pulse and saturate at all-ones, with no wrap.
- clr_stats: counters go to 0 and drop_error goes to 0. If an event coincides with clr_stats, the event is applied after the clear: a counter becomes 1, and drop_error becomes 1 on a simultaneous drop.
- Data path and clr_stats: clr_stats never affects FIFO contents or pointers.
- Reset values: m_tvalid=0, empty=1, full=0, level=0, drop_error=0, frame_err_cnt=0, overrun_err_cnt=0. Pointers are 0; memory contents are not reset.
- Reset mid-operation: reset discards all stored bytes and has priority over every other input in the same cycle.

## Timing
- Write→read latency: a byte strobed in cycle N gives m_tvalid=1 and m_tdata equal to that byte in cycle N+1.
- Pop timing: a pop in cycle N presents the next entry (or m_tvalid=0) in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- Full with pop: when full and popping in the same cycle, the push is accepted and full stays 1.
- Empty: pop is impossible when empty (m_tvalid=0), so a push into an empty FIFO always succeeds.
- Flag and counter latency: level, full, empty, drop_error and the counters are all registered, updating in the cycle after the causing event.
- Input timing: m_tready may be asserted without m_tvalid; no pop occurs. There are no combinational paths from inputs to outputs except rd_ptr→m_tdata.

## Structure
- Package uart_pkg holds:
  - the default width/depth constants;
  - a clog2-derived pointer-width localparam helper;
  - a shared saturating-increment function, reused by the TX-side statistics.
- One sub-module, uart_sync_fifo: the generic memory, pointers and level logic with push/pop/full/empty.
- uart_rx_fifo instantiates uart_sync_fifo and adds:
  - the drop/sticky logic;
  - the error counters;
  - the stream output mapping.

## Test plan
- Basic order: reset, push 0x41,0x42,0x43 on separate cycles with m_tready=0. Expect level=3; then m_tready=1 yields 0x41,0x42,0x43 in consecutive cycles, then empty=1.
- Fall-through latency: push 0x5A in cycle N with m_tready=1. Expect m_tvalid=1, m_tdata=0x5A in N+1, and empty again in N+2.
- Overflow: fill 16 bytes 0x00..0x0F, then push 0xFF with m_tready=0. Expect full=1, drop_error=1, level=16, and a drain returning 0x00..0x0F only.
- Full with simultaneous pop: with the FIFO full, push 0xAA in the same cycle as a pop. Expect no drop_error, level=16, and 0xAA read last.
- Counters: 3 frame_error pulses and 2 overrun_error pulses give counts 3 and 2. Asserting clr_stats together with a frame_error pulse gives frame_err_cnt=1, overrun_err_cnt=0. With G_CNTWIDTH=4, 20 pulses saturate the count at 15.
- Reset mid-stream: with 5 bytes stored, assert rst for 1 cycle. Expect level=0, m_tvalid=0, counters 0; the next pushed byte 0x33 is read first.
